axis_header_arbiter: RTL
========================

# axis_header_arbiter

Round-robin scheduler that shares a single `axi_stream_insert_header` instance among `NUM_SRC` header requesters. It captures one header per packet from the winning source and presents it on the inserter's header port. It then holds off further grants until the inserter's output stream completes that packet (`last_out` handshake). It sits directly in front of the inserter and snoops its output handshake.

## Interface
- `NUM_SRC`, 4, number of header requesters (2..8)
- `DATA_W`, 32, header/data width in bits
- `KEEP_W`, 4, byte-enable width (`DATA_W/8`)
- `TIMEOUT_CYC`, 1024, end-of-packet watchdog limit; used only with `AXIS_HDR_ARB_TIMEOUT_EN`

Ports:
- `clk` in 1 — single clock
- `rst` in 1 — synchronous, active-high reset
- `req_valid` in `NUM_SRC` — per-source header valid
- `req_data` in `NUM_SRC*DATA_W` — packed headers; source i occupies `[i*DATA_W +: DATA_W]`
- `req_keep` in `NUM_SRC*KEEP_W` — packed header keeps
- `req_ready` out `NUM_SRC` — one-hot grant/accept pulse
- `valid_insert` out 1 — header valid to inserter
- `data_insert` out `DATA_W` — header data
- `keep_insert` out `KEEP_W` — header keep
- `byte_insert_cnt` out 3 — count of set bits in `keep_insert`
- `ready_insert` in 1 — inserter accepts the header
- `mon_valid`, `mon_ready`, `mon_last` in 1 each — copies of the inserter's `valid_out`, `ready_out` and `last_out`
- `grant_id` out `$clog2(NUM_SRC)` — source owning the current packet
- `busy` out 1 — high in every state except IDLE
- `err_timeout` out 1 — one-cycle watchdog pulse

## Operation
- The FSM has three states: IDLE, OFFER and WAIT_EOP.
- **IDLE:**
  - If any `req_valid` is high, the round-robin picker selects the first requester at or after `rr_ptr`, wrapping modulo `NUM_SRC`.
  - `req_ready[win]` is driven combinationally high in that cycle.
  - The winner's data and keep are registered, `grant_id` is set to `win`, and the FSM goes to OFFER.
- **OFFER:**
  - `valid_insert` is high and `data_insert`/`keep_insert` are stable.
  - When `ready_insert` is high, `rr_ptr` becomes `(grant_id+1) mod NUM_SRC` and the FSM goes to WAIT_EOP.
- **WAIT_EOP:**
  - The FSM stays until `mon_valid & mon_ready & mon_last`, then returns to IDLE.
- `byte_insert_cnt` is the popcount of the registered keep (0..4) and is registered together with it.
- A keep value of 0 is legal and gives a count of 0; the header is still offered.
- A `mon_*` last-handshake seen in IDLE or OFFER is ignored.
- `req_ready` is never high outside IDLE and is never high for more than one source at a time.
- A source dropping `req_valid` while not granted has no effect.

## Timing
- Reset values: `req_ready`=0, `valid_insert`=0, `data_insert`=0, `keep_insert`=0, `byte_insert_cnt`=0, `grant_id`=0, `busy`=0, `err_timeout`=0, `rr_ptr`=0, state IDLE.
- A grant in cycle t (IDLE) gives `valid_insert` high at t+1.
- An accept in cycle t gives WAIT_EOP at t+1.
- An end-of-packet handshake in cycle t gives IDLE at t+1, so the next grant can come at t+1.
- Minimum spacing between two header offers is 3 cycles, plus the packet length.
- Reset asserted mid-packet returns everything to reset values on the next edge. The captured header is discarded and the source is not re-requested.

## Configuration
- `AXIS_HDR_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT_EOP and clears on entry.
  - When it reaches `TIMEOUT_CYC-1` with no end of packet, `err_timeout` pulses for one cycle and the FSM goes to IDLE.
- Not defined:
  - No counter is built and `err_timeout` is tied to 0.
  - WAIT_EOP waits indefinitely.

## Structure
- Package `axis_hdr_pkg` holds:
  - the state enum (IDLE/OFFER/WAIT_EOP);
  - the `DATA_W`/`KEEP_W` defaults;
  - a `popcount_keep` function.
- Sub-module `axis_rr_picker` takes the request vector and pointer and returns one-hot and binary winners. It is combinational and reused by the top.

## Test plan
- Reset, then `req_valid`=0001 with data 0x12345678 and keep 1111 → `req_ready`=0001 for one cycle; next cycle `valid_insert`=1, `byte_insert_cnt`=4, `grant_id`=0.
- All four sources request continuously and each packet ends after 2 beats → grants go in order 0,1,2,3,0, each shown by a one-hot `req_ready`.
- Keep 0011 from source 2 with `ready_insert` held low for 5 cycles → `valid_insert` and `data_insert` stay stable and `byte_insert_cnt`=2 throughout; accept happens on the first high `ready_insert`.
- `mon_last` handshake pulsed while in OFFER → ignored and no grant issued; a pulse in WAIT_EOP → IDLE on the next cycle.
- Reset asserted in WAIT_EOP → all outputs 0 next cycle and `rr_ptr`=0, so source 0 is granted first afterwards.
- With `AXIS_HDR_ARB_TIMEOUT_EN` and `TIMEOUT_CYC`=16, no end of packet → `err_timeout` pulses once at the 16th WAIT_EOP cycle, then the next requester is granted.

Source files
------------

// File: rtl/axis_hdr_pkg.sv
// Shared types, width defaults and helpers for the AXI-Stream header arbiter.
package axis_hdr_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int KEEP_W_DEFAULT = DATA_W_DEFAULT / 8;
    localparam int KEEP_MAX_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OFFER    = 2'd1,
        ST_WAIT_EOP = 2'd2
    } arb_state_t;

    // Number of enabled bytes in a header keep; narrower keeps are zero-extended.
    function automatic logic [3:0] popcount_keep(input logic [KEEP_MAX_W-1:0] keep);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_MAX_W; i++) begin
            cnt = cnt + {3'd0, keep[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_SRC; returns one-hot and binary winners.
module axis_rr_picker #(
    parameter  int NUM_SRC = 4,
    localparam int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any
);

    always_comb begin
        int          idx;
        logic [ID_W-1:0] idx_b;
        // NOTE: every output gets a default before the search so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = 0;
        idx_b    = '0;
        for (int off = 0; off < NUM_SRC; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            idx_b = ID_W'(idx);
            if (!any && req[idx_b]) begin
                any          = 1'b1;
                grant[idx_b] = 1'b1;
                grant_id     = idx_b;
            end
        end
    end

endmodule

// File: rtl/axis_header_arbiter.sv
// Round-robin header scheduler in front of one axi_stream_insert_header.
// Optional end-of-packet watchdog: define AXIS_HDR_ARB_TIMEOUT_EN.
module axis_header_arbiter #(
    parameter  int NUM_SRC     = 4,
    parameter  int DATA_W      = axis_hdr_pkg::DATA_W_DEFAULT,
    parameter  int KEEP_W      = axis_hdr_pkg::KEEP_W_DEFAULT,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int ID_W        = $clog2(NUM_SRC)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         req_valid,
    input  logic [NUM_SRC*DATA_W-1:0]  req_data,
    input  logic [NUM_SRC*KEEP_W-1:0]  req_keep,
    output logic [NUM_SRC-1:0]         req_ready,
    output logic                       valid_insert,
    output logic [DATA_W-1:0]          data_insert,
    output logic [KEEP_W-1:0]          keep_insert,
    output logic [2:0]                 byte_insert_cnt,
    input  logic                       ready_insert,
    input  logic                       mon_valid,
    input  logic                       mon_ready,
    input  logic                       mon_last,
    output logic [ID_W-1:0]            grant_id,
    output logic                       busy,
    output logic                       err_timeout
);

    import axis_hdr_pkg::*;

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     rr_ptr_nxt;
    logic [NUM_SRC-1:0]  pick_grant;
    logic [ID_W-1:0]     pick_id;
    logic                pick_any;
    logic [DATA_W-1:0]   win_data;
    logic [KEEP_W-1:0]   win_keep;
    logic                eop;
    logic                tmo_hit;

    axis_rr_picker #(
        .NUM_SRC (NUM_SRC)
    ) u_picker (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .grant    (pick_grant),
        .grant_id (pick_id),
        .any      (pick_any)
    );

    // One-hot grant lets the header mux be a plain AND-OR tree.
    always_comb begin
        win_data = '0;
        win_keep = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pick_grant[i]) begin
                win_data = win_data | req_data[i*DATA_W +: DATA_W];
                win_keep = win_keep | req_keep[i*KEEP_W +: KEEP_W];
            end
        end
    end

    assign eop        = mon_valid & mon_ready & mon_last;
    assign rr_ptr_nxt = (grant_id == ID_W'(NUM_SRC - 1)) ? '0 : grant_id + ID_W'(1);

`ifdef AXIS_HDR_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    logic [TMO_W-1:0] tmo_cnt;

    // Held at zero outside WAIT_EOP, so every packet starts counting from 0.
    always_ff @(posedge clk) begin
        if (rst || state != ST_WAIT_EOP) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign tmo_hit = (state == ST_WAIT_EOP) && !eop && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = (TIMEOUT_CYC > 0);
    assign tmo_hit        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: state and datapath registers use non-blocking assignments so every
        // flop samples the pre-edge values regardless of block ordering.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (pick_any)        state_nxt = ST_OFFER;
            ST_OFFER:    if (ready_insert)    state_nxt = ST_WAIT_EOP;
            ST_WAIT_EOP: if (eop || tmo_hit)  state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = '0;
        valid_insert = 1'b0;
        busy         = 1'b0;
        err_timeout  = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = pick_grant;
            end
            ST_OFFER: begin
                valid_insert = 1'b1;
                busy         = 1'b1;
            end
            ST_WAIT_EOP: begin
                busy        = 1'b1;
                err_timeout = tmo_hit;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Header is captured on the grant edge and held untouched until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_insert     <= '0;
            keep_insert     <= '0;
            byte_insert_cnt <= '0;
            grant_id        <= '0;
            rr_ptr          <= '0;
        end else begin
            if (state == ST_IDLE && pick_any) begin
                data_insert     <= win_data;
                keep_insert     <= win_keep;
                byte_insert_cnt <= 3'(popcount_keep(KEEP_MAX_W'(win_keep)));
                grant_id        <= pick_id;
            end
            if (state == ST_OFFER && ready_insert) begin
                rr_ptr <= rr_ptr_nxt;
            end
        end
    end

endmodule
